// File: rtl/onchip_ram_pkg.sv
// Shared definitions for the simple dual-port on-chip RAM: controller state
// encoding and the read-during-write mode constants.
package onchip_ram_pkg;

    // Controller states: CLEAR zero-fills the array, READY serves accesses.
    typedef enum logic [0:0] {
        StClear = 1'b0,
        StReady = 1'b1
    } ram_state_e;

    // Same-address read-during-write behaviour.
    localparam int unsigned RDW_OLD = 0;  // read returns the pre-write word
    localparam int unsigned RDW_NEW = 1;  // read returns the post-write word

endpackage

// File: rtl/onchip_ram_core.sv
// Plain storage array with per-lane write and a registered read port.
// Kept free of reset and control logic so it maps onto block RAM; a write and
// a read to the same address in one cycle return the old contents.
module onchip_ram_core
    import onchip_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                       i_sys_clk,
    input  logic [DATA_W/BYTE_W-1:0]   i_we,
    input  logic [ADDR_W-1:0]          i_waddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_re,
    input  logic [ADDR_W-1:0]          i_raddr,
    output logic [DATA_W-1:0]          o_rdata
);

    localparam int unsigned NumLanes = DATA_W / BYTE_W;
    localparam int unsigned Depth    = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [Depth];
    logic [DATA_W-1:0] rdata_q;

    // Per-lane write; lanes with a clear enable bit keep their contents.
    always_ff @(posedge i_sys_clk) begin
        for (int unsigned l = 0; l < NumLanes; l++) begin
            if (i_we[l]) begin
                mem[i_waddr][l*BYTE_W +: BYTE_W] <= i_wdata[l*BYTE_W +: BYTE_W];
            end
        end
    end

    // Registered read (read-first with respect to a same-edge write).
    always_ff @(posedge i_sys_clk) begin
        if (i_re) begin
            rdata_q <= mem[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/onchip_ram_sdp.sv
// Simple dual-port RAM controller: one write port (A), one read port (B),
// optional zero-fill after reset, selectable read-during-write behaviour and a
// read latency of 1 or 2 clocks after the core's registered read.
//
// Read timing: a request sampled at edge N is read from the core at edge N,
// optionally staged once more, and lands in the output register at edge
// N+RD_LAT, where o_validb strobes for one cycle. Any RD_LAT other than 2 is
// treated as 1.
module onchip_ram_sdp
    import onchip_ram_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BYTE_W     = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                      i_sys_clk,
    input  logic                      i_rst_n,
    input  logic                      i_ena,
    input  logic [DATA_W/BYTE_W-1:0]  i_wea,
    input  logic [ADDR_W-1:0]         i_addra,
    input  logic [DATA_W-1:0]         i_dina,
    input  logic                      i_enb,
    input  logic [ADDR_W-1:0]         i_addrb,
    output logic [DATA_W-1:0]         o_doutb,
    output logic                      o_validb,
    output logic                      o_busy,
    output logic                      o_reject
);

    localparam int unsigned NumLanes = DATA_W / BYTE_W;

    // Controller state and clear counter (one spare bit flags the terminal count).
    ram_state_e          state_q, state_d;
    logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
    logic                busy;
    logic                ready;

    // Core port signals.
    logic [NumLanes-1:0] core_we;
    logic [ADDR_W-1:0]   core_waddr;
    logic [DATA_W-1:0]   core_wdata;
    logic                core_re;
    logic [DATA_W-1:0]   core_rdata;

    // Read pipeline and same-address bypass capture.
    logic                rd_req_q;
    logic                byp_hit_d, byp_hit_q;
    logic [NumLanes-1:0] byp_be_q;
    logic [DATA_W-1:0]   byp_data_q;
    logic [DATA_W-1:0]   merged;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;

    // Output registers.
    logic                validb_q;
    logic [DATA_W-1:0]   doutb_q;
    logic                reject_q;

    // State register; reset restarts the clear from address 0.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= (INIT_CLEAR != 0) ? StClear : StReady;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state: step the clear address once per clock until it carries out.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy      = 1'b0;
        unique case (state_q)
            StClear: begin
                busy      = 1'b1;
                clr_cnt_d = clr_cnt_q + (ADDR_W + 1)'(1);
                if (clr_cnt_d[ADDR_W]) begin
                    state_d   = StReady;
                    clr_cnt_d = '0;
                end
            end
            StReady: begin
                state_d = StReady;
            end
        endcase
    end

    assign ready = (state_q == StReady);

    // Core port muxing: the clear sequence owns the write port while busy.
    always_comb begin
        core_we    = '0;
        core_waddr = i_addra;
        core_wdata = i_dina;
        if (busy) begin
            core_we    = {NumLanes{1'b1}};
            core_waddr = clr_cnt_q[ADDR_W-1:0];
            core_wdata = '0;
        end else if (i_ena) begin
            core_we    = i_wea;
        end
        core_re   = i_enb && ready;
        byp_hit_d = ready && i_ena && i_enb && (i_addra == i_addrb);
    end

    onchip_ram_core #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .i_sys_clk (i_sys_clk),
        .i_we      (core_we),
        .i_waddr   (core_waddr),
        .i_wdata   (core_wdata),
        .i_re      (core_re),
        .i_raddr   (i_addrb),
        .o_rdata   (core_rdata)
    );

    // Track the read issued to the core and any same-address write beside it.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_req_q   <= 1'b0;
            byp_hit_q  <= 1'b0;
            byp_be_q   <= '0;
            byp_data_q <= '0;
        end else begin
            rd_req_q   <= core_re;
            byp_hit_q  <= byp_hit_d;
            byp_be_q   <= i_wea;
            byp_data_q <= i_dina;
        end
    end

    // New-data mode overlays the written lanes on the core's pre-write word.
    always_comb begin
        merged = core_rdata;
        if ((RDW_MODE == RDW_NEW) && byp_hit_q) begin
            for (int unsigned l = 0; l < NumLanes; l++) begin
                if (byp_be_q[l]) begin
                    merged[l*BYTE_W +: BYTE_W] = byp_data_q[l*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              stg_valid_q;
        logic [DATA_W-1:0] stg_data_q;

        // Extra stage for the two-clock latency option.
        always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                stg_valid_q <= 1'b0;
                stg_data_q  <= '0;
            end else begin
                stg_valid_q <= rd_req_q;
                if (rd_req_q) begin
                    stg_data_q <= merged;
                end
            end
        end

        assign out_valid = stg_valid_q;
        assign out_data  = stg_data_q;
    end else begin : g_lat1
        assign out_valid = rd_req_q;
        assign out_data  = merged;
    end

    // Output register: data only loads on a valid result, otherwise holds.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            validb_q <= 1'b0;
            doutb_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            validb_q <= out_valid;
            if (out_valid) begin
                doutb_q <= out_data;
            end
            reject_q <= busy && (i_ena || i_enb);
        end
    end

    assign o_doutb  = doutb_q;
    assign o_validb = validb_q;
    assign o_busy   = busy;
    assign o_reject = reject_q;

endmodule

// File: tb/tb_onchip_ram_sdp.sv
// Directed bench for onchip_ram_sdp. Two instances share one stimulus stream:
// u_dut1 uses defaults (RD_LAT=1, old-data RDW), u_dut2 uses RD_LAT=2 with
// new-data RDW. Inputs are driven and outputs sampled on the falling edge.
module tb_onchip_ram_sdp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [1:0]  wea = '0;
    logic [7:0]  addra = '0;
    logic [15:0] dina = '0;
    logic        enb = 1'b0;
    logic [7:0]  addrb = '0;

    logic [15:0] dout1, dout2;
    logic        v1, v2, busy1, busy2, rej1, rej2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    onchip_ram_sdp #(
        .DATA_W (16), .BYTE_W (8), .ADDR_W (8),
        .RD_LAT (1), .RDW_MODE (0), .INIT_CLEAR (1)
    ) u_dut1 (
        .i_sys_clk (clk), .i_rst_n (rst_n),
        .i_ena (ena), .i_wea (wea), .i_addra (addra), .i_dina (dina),
        .i_enb (enb), .i_addrb (addrb),
        .o_doutb (dout1), .o_validb (v1), .o_busy (busy1), .o_reject (rej1)
    );

    onchip_ram_sdp #(
        .DATA_W (16), .BYTE_W (8), .ADDR_W (8),
        .RD_LAT (2), .RDW_MODE (1), .INIT_CLEAR (1)
    ) u_dut2 (
        .i_sys_clk (clk), .i_rst_n (rst_n),
        .i_ena (ena), .i_wea (wea), .i_addra (addra), .i_dina (dina),
        .i_enb (enb), .i_addrb (addrb),
        .o_doutb (dout2), .o_validb (v2), .o_busy (busy2), .o_reject (rej2)
    );

    function automatic logic [15:0] fill_pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b ^ 8'h5A, b};
    endfunction

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        @(negedge clk);
        ena = 1'b1; addra = a; dina = d; wea = be;
        @(negedge clk);
        ena = 1'b0; wea = '0;
    endtask

    // Issue one read (optionally with a concurrent write) and capture the
    // valid strobes one, two and three edges after the sampling edge.
    task automatic rd_obs(input logic [7:0] a, input logic w_en, input logic [7:0] wa,
                          input logic [15:0] wd, input logic [1:0] wbe,
                          output logic [2:0] vo1, output logic [2:0] vo2,
                          output logic [15:0] do1, output logic [15:0] do2);
        @(negedge clk);
        enb = 1'b1; addrb = a; ena = w_en; addra = wa; dina = wd; wea = wbe;
        @(negedge clk);
        enb = 1'b0; ena = 1'b0; wea = '0;
        vo1[0] = v1; vo2[0] = v2;
        @(negedge clk);
        vo1[1] = v1; vo2[1] = v2; do1 = dout1;
        @(negedge clk);
        vo1[2] = v1; vo2[2] = v2; do2 = dout2;
    endtask

    task automatic test_reset;
        int cnt;
        logic [2:0] a1, a2;
        logic [15:0] b1, b2;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({dout1, v1, rej1, busy1} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state_dut1: got %h/%b/%b/%b want 0000/0/0/1", dout1, v1, rej1, busy1);
        end
        n_cmp++;
        if ({dout2, v2, rej2, busy2} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state_dut2: got %h/%b/%b/%b want 0000/0/0/1", dout2, v2, rej2, busy2);
        end
        rst_n = 1'b1;
        cnt = 0;
        while (busy1 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt !== 256) begin
            n_err++;
            $display("FAIL busy_cycles: got %0d want 256", cnt);
        end
        n_cmp++;
        if (busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL busy_end_dut2: got %b want 0", busy2);
        end
        rd_obs(8'h00, 1'b0, 8'h00, 16'h0, 2'b00, a1, a2, b1, b2);
        n_cmp++;
        if ({a1, b1} !== {3'b010, 16'h0000}) begin
            n_err++;
            $display("FAIL clr_rd00_dut1: got v=%b d=%h want v=010 d=0000", a1, b1);
        end
        n_cmp++;
        if ({a2, b2} !== {3'b100, 16'h0000}) begin
            n_err++;
            $display("FAIL clr_rd00_dut2: got v=%b d=%h want v=100 d=0000", a2, b2);
        end
        rd_obs(8'hFF, 1'b0, 8'h00, 16'h0, 2'b00, a1, a2, b1, b2);
        n_cmp++;
        if ({a1, b1, a2, b2} !== {3'b010, 16'h0000, 3'b100, 16'h0000}) begin
            n_err++;
            $display("FAIL clr_rdFF: got %b %h %b %h want 010 0000 100 0000", a1, b1, a2, b2);
        end
    endtask

    task automatic test_full_word;
        logic [2:0] a1, a2;
        logic [15:0] b1, b2;
        wr(8'h10, 16'hA5C3, 2'b11);
        rd_obs(8'h10, 1'b0, 8'h00, 16'h0, 2'b00, a1, a2, b1, b2);
        n_cmp++;
        if ({a1, b1} !== {3'b010, 16'hA5C3}) begin
            n_err++;
            $display("FAIL full_word_lat1: got v=%b d=%h want v=010 d=a5c3", a1, b1);
        end
        n_cmp++;
        if ({a2, b2} !== {3'b100, 16'hA5C3}) begin
            n_err++;
            $display("FAIL full_word_lat2: got v=%b d=%h want v=100 d=a5c3", a2, b2);
        end
    endtask

    task automatic test_byte_lanes;
        logic [2:0] a1, a2;
        logic [15:0] b1, b2;
        wr(8'h20, 16'h1234, 2'b11);
        wr(8'h20, 16'hFF00, 2'b10);
        rd_obs(8'h20, 1'b0, 8'h00, 16'h0, 2'b00, a1, a2, b1, b2);
        n_cmp++;
        if ({a1, b1, a2, b2} !== {3'b010, 16'hFF34, 3'b100, 16'hFF34}) begin
            n_err++;
            $display("FAIL lane_hi: got %b %h %b %h want 010 ff34 100 ff34", a1, b1, a2, b2);
        end
        wr(8'h20, 16'hDEAD, 2'b00);
        rd_obs(8'h20, 1'b0, 8'h00, 16'h0, 2'b00, a1, a2, b1, b2);
        n_cmp++;
        if ({b1, b2} !== {16'hFF34, 16'hFF34}) begin
            n_err++;
            $display("FAIL lane_none: got %h %h want ff34 ff34", b1, b2);
        end
    endtask

    task automatic test_rdw;
        logic [2:0] a1, a2;
        logic [15:0] b1, b2;
        wr(8'h30, 16'h1111, 2'b11);
        rd_obs(8'h30, 1'b1, 8'h30, 16'h2222, 2'b11, a1, a2, b1, b2);
        n_cmp++;
        if ({a1, b1} !== {3'b010, 16'h1111}) begin
            n_err++;
            $display("FAIL rdw_old: got v=%b d=%h want v=010 d=1111", a1, b1);
        end
        n_cmp++;
        if ({a2, b2} !== {3'b100, 16'h2222}) begin
            n_err++;
            $display("FAIL rdw_new: got v=%b d=%h want v=100 d=2222", a2, b2);
        end
        // Low lane only: old mode sees 2222, new mode sees the merged 22aa.
        rd_obs(8'h30, 1'b1, 8'h30, 16'h33AA, 2'b01, a1, a2, b1, b2);
        n_cmp++;
        if ({b1, b2} !== {16'h2222, 16'h22AA}) begin
            n_err++;
            $display("FAIL rdw_lane: got %h %h want 2222 22aa", b1, b2);
        end
        rd_obs(8'h30, 1'b0, 8'h00, 16'h0, 2'b00, a1, a2, b1, b2);
        n_cmp++;
        if ({b1, b2} !== {16'h22AA, 16'h22AA}) begin
            n_err++;
            $display("FAIL rdw_after: got %h %h want 22aa 22aa", b1, b2);
        end
    endtask

    task automatic test_diff_addr;
        logic [2:0] a1, a2;
        logic [15:0] b1, b2;
        rd_obs(8'h10, 1'b1, 8'h50, 16'h5555, 2'b11, a1, a2, b1, b2);
        n_cmp++;
        if ({a1, b1, a2, b2} !== {3'b010, 16'hA5C3, 3'b100, 16'hA5C3}) begin
            n_err++;
            $display("FAIL diff_rd: got %b %h %b %h want 010 a5c3 100 a5c3", a1, b1, a2, b2);
        end
        rd_obs(8'h50, 1'b0, 8'h00, 16'h0, 2'b00, a1, a2, b1, b2);
        n_cmp++;
        if ({b1, b2} !== {16'h5555, 16'h5555}) begin
            n_err++;
            $display("FAIL diff_wr: got %h %h want 5555 5555", b1, b2);
        end
    endtask

    task automatic test_hold;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({v1, dout1, v2, dout2} !== {1'b0, 16'h5555, 1'b0, 16'h5555}) begin
            n_err++;
            $display("FAIL hold: got %b %h %b %h want 0 5555 0 5555", v1, dout1, v2, dout2);
        end
    endtask

    task automatic test_reset_mid_clear;
        int cnt;
        logic saw_v;
        logic r6a, r6b, r7a;
        logic [2:0] a1, a2;
        logic [15:0] b1, b2;
        // Reset right after a read is sampled: it must never strobe.
        @(negedge clk);
        enb = 1'b1; addrb = 8'h10;
        @(negedge clk);
        enb = 1'b0; rst_n = 1'b0;
        saw_v = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (v1 || v2) saw_v = 1'b1;
        end
        n_cmp++;
        if ({saw_v, dout1, busy1} !== {1'b0, 16'h0, 1'b1}) begin
            n_err++;
            $display("FAIL abort_rd: got v=%b d=%h busy=%b want 0 0000 1", saw_v, dout1, busy1);
        end
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        n_cmp++;
        if (busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL busy_mid: got %b want 1", busy1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0; saw_v = 1'b0; r6a = 1'b0; r6b = 1'b0; r7a = 1'b1;
        while (busy1 && cnt < 400) begin
            if (cnt == 5) begin
                ena = 1'b1; wea = 2'b11; addra = 8'h40; dina = 16'hBEEF;
                enb = 1'b1; addrb = 8'h40;
            end else begin
                ena = 1'b0; wea = 2'b00; enb = 1'b0;
            end
            if (cnt == 6) begin
                r6a = rej1; r6b = rej2;
            end
            if (cnt == 7) r7a = rej1;
            if (v1 || v2) saw_v = 1'b1;
            cnt++;
            @(negedge clk);
        end
        ena = 1'b0; enb = 1'b0; wea = 2'b00;
        n_cmp++;
        if (cnt !== 256) begin
            n_err++;
            $display("FAIL busy_restart: got %0d want 256", cnt);
        end
        n_cmp++;
        if ({r6a, r6b, r7a} !== 3'b110) begin
            n_err++;
            $display("FAIL reject_pulse: got %b want 110", {r6a, r6b, r7a});
        end
        n_cmp++;
        if (saw_v !== 1'b0) begin
            n_err++;
            $display("FAIL valid_in_clear: got %b want 0", saw_v);
        end
        rd_obs(8'h40, 1'b0, 8'h00, 16'h0, 2'b00, a1, a2, b1, b2);
        n_cmp++;
        if ({a1, b1, a2, b2} !== {3'b010, 16'h0000, 3'b100, 16'h0000}) begin
            n_err++;
            $display("FAIL rejected_wr: got %b %h %b %h want 010 0000 100 0000", a1, b1, a2, b2);
        end
        rd_obs(8'h10, 1'b0, 8'h00, 16'h0, 2'b00, a1, a2, b1, b2);
        n_cmp++;
        if ({b1, b2} !== {16'h0000, 16'h0000}) begin
            n_err++;
            $display("FAIL recleared: got %h %h want 0000 0000", b1, b2);
        end
    endtask

    task automatic test_back_to_back;
        logic ev1, ev2;
        int pulses1;
        pulses1 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ena = 1'b1; wea = 2'b11; addra = i[7:0]; dina = fill_pat(i);
        end
        @(negedge clk);
        ena = 1'b0; wea = 2'b00;
        for (int j = 0; j < 260; j++) begin
            @(negedge clk);
            ev1 = (j >= 2) && (j < 258);
            ev2 = (j >= 3) && (j < 259);
            if (v1) pulses1++;
            n_cmp++;
            if (v1 !== ev1 || (ev1 && dout1 !== fill_pat(j - 2))) begin
                n_err++;
                $display("FAIL stream_dut1[%0d]: got v=%b d=%h want v=%b d=%h",
                         j, v1, dout1, ev1, fill_pat(j - 2));
            end
            n_cmp++;
            if (v2 !== ev2 || (ev2 && dout2 !== fill_pat(j - 3))) begin
                n_err++;
                $display("FAIL stream_dut2[%0d]: got v=%b d=%h want v=%b d=%h",
                         j, v2, dout2, ev2, fill_pat(j - 3));
            end
            enb = (j < 256);
            addrb = j[7:0];
        end
        enb = 1'b0;
        n_cmp++;
        if (pulses1 !== 256) begin
            n_err++;
            $display("FAIL stream_pulses: got %0d want 256", pulses1);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_byte_lanes();
        test_rdw();
        test_diff_addr();
        test_hold();
        test_reset_mid_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/onchip_ram_sdp.md
ONCHIP_RAM_SDP -- requirements
Module: onchip_ram_sdp

Interface
REQ-001 SHALL have parameter DATA_W, default 16, read/write data width in bits; must be a multiple of BYTE_W.
REQ-002 SHALL have parameter BYTE_W, default 8, width of one write-enable lane.
REQ-003 SHALL have parameter ADDR_W, default 8, address width; depth = 2^ADDR_W words.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in clocks; only 1 or 2 legal.
REQ-005 SHALL have parameter RDW_MODE, default 0, same-address read-during-write behaviour: 0 = old data, 1 = new data.
REQ-006 SHALL have parameter INIT_CLEAR, default 1, which zero-fills memory after reset when 1.
REQ-007 i_sys_clk  input  1  single clock for all logic; one clock, no other clock domain.
REQ-008 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 i_ena  input  1  port A (write) enable.
REQ-010 i_wea  input  DATA_W/BYTE_W  per-lane write enable.
REQ-011 i_addra  input  ADDR_W  write address.
REQ-012 i_dina  input  DATA_W  write data.
REQ-013 i_enb  input  1  port B (read) request.
REQ-014 i_addrb  input  ADDR_W  read address.
REQ-015 o_doutb  output  DATA_W  read data.
REQ-016 o_validb  output  1  one-cycle strobe marking o_doutb valid.
REQ-017 o_busy  output  1  high while the clear sequence runs.
REQ-018 o_reject  output  1  one-cycle pulse when an access arrives while busy.

Function
REQ-019 FSM SHALL have states CLEAR and READY; after reset it SHALL enter CLEAR if INIT_CLEAR=1, else READY.
REQ-020 In CLEAR it SHALL write zero to one address per clock, from 0 up to 2^ADDR_W-1, then go to READY on the next edge; o_busy SHALL be high for exactly 2^ADDR_W cycles.
REQ-021 In CLEAR, i_ena and i_enb SHALL be ignored; either one high SHALL pulse o_reject the next cycle, and o_validb SHALL stay 0.
REQ-022 In READY, a write with i_ena=1 SHALL update only the lanes whose i_wea bit is 1; i_ena=1 with i_wea all-zero SHALL change nothing.
REQ-023 A read with i_enb=1 sampled at edge N SHALL present data on o_doutb, with o_validb=1, for one cycle after edge N+RD_LAT-1+1 (RD_LAT=1: next cycle; RD_LAT=2: one cycle later).
REQ-024 Back-to-back reads SHALL sustain one result per clock with no bubbles.
REQ-025 o_doutb SHALL hold its last value when o_validb=0.
REQ-026 For a same-cycle write and read to one address: RDW_MODE=0 SHALL return pre-write data; RDW_MODE=1 SHALL return the post-write word, merged per lane.
REQ-027 Reads and writes to different addresses in the same cycle SHALL both complete with no interaction.
REQ-028 Clear address counter SHALL be ADDR_W+1 bits so that the terminal count is detected without wrap ambiguity.

Reset
REQ-029 While i_rst_n=0: o_doutb=0, o_validb=0, o_reject=0, read pipeline flushed, o_busy=INIT_CLEAR.
REQ-030 Reset mid-clear SHALL restart the clear at address 0; reset SHALL abort in-flight reads with no o_validb.
REQ-031 Memory array SHALL NOT be reset directly; only the clear sequence zeroes it.

Structure
REQ-032 Package onchip_ram_pkg SHALL hold the FSM state encoding and the RDW_MODE constants (RDW_OLD=0, RDW_NEW=1).
REQ-033 Storage array SHALL be the sub-module onchip_ram_core: a plain array with per-lane write and registered read, suitable for block-RAM inference. FSM, bypass and latency pipeline SHALL sit in onchip_ram_sdp.

Verification
REQ-034 Defaults, INIT_CLEAR=1: release reset -> o_busy high exactly 256 cycles; reads of 0x00 and 0xFF -> 0x0000.
REQ-035 Write 0xA5C3 to 0x10 with i_wea=2'b11, read 0x10 -> o_doutb=0xA5C3 with o_validb after RD_LAT cycles; repeat with RD_LAT=2.
REQ-036 Write 0x1234 to 0x20, then write 0xFF00 to 0x20 with i_wea=2'b10, read -> 0xFF34.
REQ-037 With 0x30 holding 0x1111, same-cycle write of 0x2222 and read of 0x30 -> 0x1111 (RDW_MODE=0) or 0x2222 (RDW_MODE=1).
REQ-038 Assert reset at clear cycle 100, release -> o_busy high a full 256 cycles again; write at cycle 5 after release -> o_reject pulse, and a later read of that address returns 0x0000.
REQ-039 256 consecutive reads 0x00..0xFF after a sequential fill -> 256 consecutive o_validb pulses with matching data.
